data_ram_wait: RTL

- Word-addressed data RAM that acts as the responder to the CPU's load/store bus.
- Models a memory with a configurable number of wait states and uses a ce/ready handshake, so stall logic can be exercised in the SoC.
- Sits in the min SOPC beside the instruction ROM and is driven by the core's memory-stage outputs.
- Lanes are big-endian (MIPS).

---
 rtl/data_ram_wait_if.sv | 15 +
 rtl/data_ram_wait.sv | 103 ++++++++++
 2 files changed

// File: rtl/data_ram_wait_if.sv
// Load/store bus between the CPU memory stage (master) and the wait-state data RAM (slave).
// Carries a ce/ready handshake with a single-cycle response strobe.
interface data_ram_wait_if;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ready;
    logic        err;

    modport master (output ce, we, addr, sel, data_i, input data_o, ready, err);
    modport slave  (input ce, we, addr, sel, data_i, output data_o, ready, err);
endinterface

// File: rtl/data_ram_wait.sv
// Word-addressed big-endian data RAM with WAIT_CYCLES wait states and a one-cycle ready strobe.
// Out-of-range accesses complete with err and leave RAM and data_o untouched.
module data_ram_wait #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input logic           clk,
    input logic           rst,
    data_ram_wait_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } req_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    req_t            req_q, req_d;
    logic [31:0]     rdata_q, rdata_d;

    req_t            bus_req, req_c;
    logic            enter_resp;
    logic            oor_c, oor_q;
    logic [ADDR_WIDTH-1:0] idx_c;

    logic [3:0][7:0] mem [DEPTH];

    assign bus_req = '{we: bus.we, addr: bus.addr, sel: bus.sel, wdata: bus.data_i};

    // With no wait states the access commits on the accept edge itself, so use the live bus.
    assign req_c = (state_q == S_IDLE) ? bus_req : req_q;
    assign oor_c = |req_c.addr[31:ADDR_WIDTH+2];
    assign oor_q = |req_q.addr[31:ADDR_WIDTH+2];
    assign idx_c = req_c.addr[ADDR_WIDTH+1:2];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.ce) begin
                    req_d = bus_req;
                    cnt_d = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (enter_resp && !req_c.we && !oor_c) rdata_d = mem[idx_c];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM is not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && req_c.we && !oor_c) begin
            for (int l = 0; l < 4; l++) begin
                if (req_c.sel[l]) mem[idx_c][l] <= req_c.wdata[8*l +: 8];
            end
        end
    end

    assign bus.ready  = (state_q == S_RESP);
    assign bus.err    = (state_q == S_RESP) && oor_q;
    assign bus.data_o = rdata_q;
endmodule
